// File: rtl/bip_acc_datapath_pkg.sv
// Shared encodings for the BIP accumulator datapath: opcodes, ACC source
// selects, flag bit positions and the multiplier FSM states.
package bip_dp_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SAR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam logic [1:0] SELA_DM  = 2'b00;
  localparam logic [1:0] SELA_IMM = 2'b01;
  localparam logic [1:0] SELA_ALU = 2'b10;
  localparam logic [1:0] SELA_RSV = 2'b11;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/bip_acc_datapath_alu.sv
// Combinational single-cycle ALU (opcodes 000-110) with {Z,N,C,V} generation.
module bip_alu
  import bip_dp_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [2:0]        i_op,
  output logic [DATA_W-1:0] o_y,
  output logic [3:0]        o_flags
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W:0] w_sum;
  logic [DATA_W:0] w_dif;
  logic            w_c;
  logic            w_v;

  // Top bit of the extended difference is the unsigned borrow.
  assign w_sum = {1'b0, i_a} + {1'b0, i_b};
  assign w_dif = {1'b0, i_a} - {1'b0, i_b};

  // Result and flag selection per opcode.
  always_comb begin
    o_y = {DATA_W{1'b0}};
    w_c = 1'b0;
    w_v = 1'b0;
    case (i_op)
      OP_ADD: begin
        o_y = w_sum[MSB:0];
        w_c = w_sum[DATA_W];
        w_v = (i_a[MSB] == i_b[MSB]) && (w_sum[MSB] != i_a[MSB]);
      end
      OP_SUB: begin
        o_y = w_dif[MSB:0];
        w_c = w_dif[DATA_W];
        w_v = (i_a[MSB] != i_b[MSB]) && (w_dif[MSB] != i_a[MSB]);
      end
      OP_AND: o_y = i_a & i_b;
      OP_OR:  o_y = i_a | i_b;
      OP_XOR: o_y = i_a ^ i_b;
      OP_SHL: begin
        o_y = {i_a[MSB-1:0], 1'b0};
        w_c = i_a[MSB];
      end
      OP_SAR: begin
        o_y = {i_a[MSB], i_a[MSB:1]};
        w_c = i_a[0];
      end
      default: o_y = {DATA_W{1'b0}};
    endcase
    o_flags         = 4'b0000;
    o_flags[FLAG_Z] = (o_y == {DATA_W{1'b0}});
    o_flags[FLAG_N] = o_y[MSB];
    o_flags[FLAG_C] = w_c;
    o_flags[FLAG_V] = w_v;
  end

endmodule

// File: rtl/bip_acc_datapath.sv
// BIP accumulator datapath: operand mux/extension, ACC and FLAGS registers,
// single-cycle ALU path and a DATA_W-cycle shift-add multiplier.
module bip_acc_datapath
  import bip_dp_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int OPERAND_W = 11,
  parameter bit SIGN_EXT  = 1'b0
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic [OPERAND_W-1:0] i_operand,
  input  logic [DATA_W-1:0]    i_dm,
  input  logic [1:0]           i_sel_a,
  input  logic                 i_sel_b,
  input  logic                 i_wr_acc,
  input  logic [2:0]           i_op,
  output logic [DATA_W-1:0]    o_acc,
  output logic [3:0]           o_flags,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [OPERAND_W-1:0] o_operand
);

  localparam int EXT_W = DATA_W - OPERAND_W;
  localparam int CNT_W = $clog2(DATA_W);
  localparam int PW    = 2 * DATA_W;

  state_e              r_state;
  logic [DATA_W-1:0]   r_acc;
  logic [3:0]          r_flags;
  logic                r_done;
  logic [PW-1:0]       r_prod;
  logic [PW-1:0]       r_mcand;
  logic [DATA_W-1:0]   r_mplier;
  logic [CNT_W-1:0]    r_cnt;

  state_e              w_state_nxt;
  logic [DATA_W-1:0]   w_acc_nxt;
  logic [3:0]          w_flags_nxt;
  logic                w_done_nxt;
  logic [PW-1:0]       w_prod_nxt;
  logic [PW-1:0]       w_mcand_nxt;
  logic [DATA_W-1:0]   w_mplier_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;

  logic [DATA_W-1:0]   w_ext;
  logic [DATA_W-1:0]   w_b;
  logic [DATA_W-1:0]   w_alu_y;
  logic [3:0]          w_alu_flags;
  logic [PW-1:0]       w_step;

  function automatic logic [1:0] zn_of(input logic [DATA_W-1:0] v);
    return {(v == {DATA_W{1'b0}}), v[DATA_W-1]};
  endfunction

  assign w_ext = SIGN_EXT ? {{EXT_W{i_operand[OPERAND_W-1]}}, i_operand}
                          : {{EXT_W{1'b0}}, i_operand};
  assign w_b   = i_sel_b ? i_dm : w_ext;
  // One shift-add iteration: add the shifted multiplicand when the current multiplier bit is set.
  assign w_step = r_prod + (r_mplier[0] ? r_mcand : {PW{1'b0}});

  bip_alu #(.DATA_W(DATA_W)) u_alu (
    .i_a     (r_acc),
    .i_b     (w_b),
    .i_op    (i_op),
    .o_y     (w_alu_y),
    .o_flags (w_alu_flags)
  );

  // Next-state, accumulator and multiplier register updates.
  always_comb begin
    w_state_nxt  = r_state;
    w_acc_nxt    = r_acc;
    w_flags_nxt  = r_flags;
    w_done_nxt   = 1'b0;
    w_prod_nxt   = r_prod;
    w_mcand_nxt  = r_mcand;
    w_mplier_nxt = r_mplier;
    w_cnt_nxt    = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (i_wr_acc) begin
          case (i_sel_a)
            SELA_DM: begin
              w_acc_nxt                   = i_dm;
              w_flags_nxt[FLAG_Z:FLAG_N]  = zn_of(i_dm);
            end
            SELA_IMM: begin
              w_acc_nxt                   = w_ext;
              w_flags_nxt[FLAG_Z:FLAG_N]  = zn_of(w_ext);
            end
            SELA_ALU: begin
              if (i_op == OP_MUL) begin
                w_state_nxt  = ST_MUL;
                w_prod_nxt   = {PW{1'b0}};
                w_mcand_nxt  = {{DATA_W{1'b0}}, r_acc};
                w_mplier_nxt = w_b;
                w_cnt_nxt    = {CNT_W{1'b0}};
              end else begin
                w_acc_nxt   = w_alu_y;
                w_flags_nxt = w_alu_flags;
              end
            end
            default: w_acc_nxt = r_acc;
          endcase
        end else begin
          w_acc_nxt = r_acc;
        end
      end
      ST_MUL: begin
        w_prod_nxt   = w_step;
        w_mcand_nxt  = {r_mcand[PW-2:0], 1'b0};
        w_mplier_nxt = {1'b0, r_mplier[DATA_W-1:1]};
        w_cnt_nxt    = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(DATA_W - 1)) begin
          w_state_nxt                = ST_IDLE;
          w_done_nxt                 = 1'b1;
          w_acc_nxt                  = w_step[DATA_W-1:0];
          w_flags_nxt[FLAG_Z:FLAG_N] = zn_of(w_step[DATA_W-1:0]);
          w_flags_nxt[FLAG_C]        = |w_step[PW-1:DATA_W];
          w_flags_nxt[FLAG_V]        = 1'b0;
        end else begin
          w_state_nxt = ST_MUL;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state  <= ST_IDLE;
      r_acc    <= {DATA_W{1'b0}};
      r_flags  <= 4'b0000;
      r_done   <= 1'b0;
      r_prod   <= {PW{1'b0}};
      r_mcand  <= {PW{1'b0}};
      r_mplier <= {DATA_W{1'b0}};
      r_cnt    <= {CNT_W{1'b0}};
    end else begin
      r_state  <= w_state_nxt;
      r_acc    <= w_acc_nxt;
      r_flags  <= w_flags_nxt;
      r_done   <= w_done_nxt;
      r_prod   <= w_prod_nxt;
      r_mcand  <= w_mcand_nxt;
      r_mplier <= w_mplier_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign o_acc     = r_acc;
  assign o_flags   = r_flags;
  assign o_busy    = (r_state == ST_MUL);
  assign o_done    = r_done;
  assign o_operand = i_operand;

endmodule

// File: tb/tb_bip_acc_datapath.sv
// Bench for bip_acc_datapath: zero- and sign-extending instances driven in
// parallel, checked each cycle against an arithmetic reference model.
module tb_bip_acc_datapath;

  localparam int DW = 16;
  localparam int OW = 11;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [OW-1:0] operand;
  logic [DW-1:0] dm;
  logic [1:0]    sel_a;
  logic          sel_b;
  logic          wr;
  logic [2:0]    op;

  logic [DW-1:0] acc_z, acc_s;
  logic [3:0]    flags_z, flags_s;
  logic          busy_z, busy_s, done_z, done_s;
  logic [OW-1:0] opo_z, opo_s;

  int tests = 0;
  int fails = 0;

  int unsigned m_acc [2];
  int unsigned m_flags [2];
  int unsigned m_prod [2];
  int          m_cnt [2];
  bit          m_busy [2];
  bit          m_done [2];

  always #5 clk = ~clk;

  bip_acc_datapath #(.DATA_W(DW), .OPERAND_W(OW), .SIGN_EXT(1'b0)) dut_z (
    .i_clk(clk), .i_reset_n(rst_n), .i_operand(operand), .i_dm(dm),
    .i_sel_a(sel_a), .i_sel_b(sel_b), .i_wr_acc(wr), .i_op(op),
    .o_acc(acc_z), .o_flags(flags_z), .o_busy(busy_z), .o_done(done_z),
    .o_operand(opo_z)
  );

  bip_acc_datapath #(.DATA_W(DW), .OPERAND_W(OW), .SIGN_EXT(1'b1)) dut_s (
    .i_clk(clk), .i_reset_n(rst_n), .i_operand(operand), .i_dm(dm),
    .i_sel_a(sel_a), .i_sel_b(sel_b), .i_wr_acc(wr), .i_op(op),
    .o_acc(acc_s), .o_flags(flags_s), .o_busy(busy_s), .o_done(done_s),
    .o_operand(opo_s)
  );

  function automatic int s16(input int unsigned x);
    return (x >= 32768) ? int'(x) - 65536 : int'(x);
  endfunction

  function automatic int unsigned mk_flags(input int unsigned r, input int unsigned c,
                                           input int unsigned v);
    return ((r == 0) ? 8 : 0) + ((r >= 32768) ? 4 : 0) + (c != 0 ? 2 : 0) + (v != 0 ? 1 : 0);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour for one rising edge, per instance (d=0 zero-ext, d=1 sign-ext).
  task automatic model_edge();
    int unsigned ext, a, b, r, c, v;
    int          sr;
    for (int d = 0; d < 2; d++) begin
      ext = operand;
      if (d == 1 && operand >= 1024) ext = ext + 32'h0000_F800;
      b = sel_b ? dm : ext;
      a = m_acc[d];
      if (!rst_n) begin
        m_acc[d] = 0; m_flags[d] = 0; m_busy[d] = 0; m_done[d] = 0;
      end else if (m_busy[d]) begin
        m_done[d] = 0;
        m_cnt[d]++;
        if (m_cnt[d] == DW) begin
          m_acc[d]   = m_prod[d] % 65536;
          m_flags[d] = mk_flags(m_acc[d], m_prod[d] / 65536, 0);
          m_busy[d]  = 0;
          m_done[d]  = 1;
        end
      end else begin
        m_done[d] = 0;
        if (wr) begin
          if (sel_a == 2'd0 || sel_a == 2'd1) begin
            m_acc[d]   = (sel_a == 2'd0) ? dm : ext;
            m_flags[d] = mk_flags(m_acc[d], 0, 0) + (m_flags[d] % 4);
          end else if (sel_a == 2'd2 && op == 3'd7) begin
            m_busy[d] = 1; m_cnt[d] = 0; m_prod[d] = a * b;
          end else if (sel_a == 2'd2) begin
            c = 0; v = 0;
            case (op)
              3'd0: begin r = a + b; c = r / 65536; sr = s16(a) + s16(b);
                          v = (sr > 32767 || sr < -32768) ? 1 : 0; end
              3'd1: begin r = (a + 65536 - b); c = (a < b) ? 1 : 0; sr = s16(a) - s16(b);
                          v = (sr > 32767 || sr < -32768) ? 1 : 0; end
              3'd2: r = a & b;
              3'd3: r = a | b;
              3'd4: r = a ^ b;
              3'd5: begin r = a * 2; c = a / 32768; end
              default: begin r = (a / 2) + ((a >= 32768) ? 32768 : 0); c = a % 2; end
            endcase
            m_acc[d]   = r % 65536;
            m_flags[d] = mk_flags(m_acc[d], c, v);
          end
        end
      end
    end
  endtask

  task automatic check_all();
    check("acc_z", acc_z, m_acc[0]);
    check("flags_z", flags_z, m_flags[0]);
    check("busy_z", busy_z, m_busy[0]);
    check("done_z", done_z, m_done[0]);
    check("acc_s", acc_s, m_acc[1]);
    check("flags_s", flags_s, m_flags[1]);
    check("busy_s", busy_s, m_busy[1]);
    check("done_s", done_s, m_done[1]);
  endtask

  task automatic drive(input logic r, input logic w, input logic [1:0] sa, input logic sb,
                       input logic [2:0] o, input logic [OW-1:0] opd, input logic [DW-1:0] d);
    rst_n = r; wr = w; sel_a = sa; sel_b = sb; op = o; operand = opd; dm = d;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    int dones;
    drive(1'b0, 1'b1, 2'b01, 1'b1, 3'b000, 11'h7FF, 16'h1234);
    step(); step();
    check("rst_acc", acc_z, 32'h0);
    check("rst_flags", flags_s, 32'h0);
    check("rst_busy", busy_z, 32'h0);
    check("rst_done", done_s, 32'h0);

    drive(1'b1, 1'b1, 2'b01, 1'b0, 3'b000, 11'h7FF, 16'h0000);
    #1;
    check("opout", opo_z, 32'h7FF);
    step();
    check("imm_zext", acc_z, 32'h07FF);
    check("imm_sext", acc_s, 32'hFFFF);
    check("imm_sext_fl", flags_s, 32'h4);

    drive(1'b1, 1'b1, 2'b00, 1'b1, 3'b000, 11'h000, 16'h7FFF); step();
    drive(1'b1, 1'b1, 2'b10, 1'b1, 3'b000, 11'h000, 16'h0001); step();
    check("add_ovf_acc", acc_z, 32'h8000);
    check("add_ovf_fl", flags_z, 32'h5);

    drive(1'b1, 1'b1, 2'b01, 1'b0, 3'b000, 11'd3, 16'h0000); step();
    drive(1'b1, 1'b1, 2'b10, 1'b0, 3'b001, 11'd5, 16'h0000); step();
    check("sub_acc", acc_s, 32'hFFFE);
    check("sub_fl", flags_s, 32'h6);
    drive(1'b1, 1'b1, 2'b10, 1'b0, 3'b101, 11'd5, 16'h0000); step();
    check("shl_acc", acc_z, 32'hFFFC);
    check("shl_fl", flags_z, 32'h6);

    // Multiply with an ignored mid-way load, then a back-to-back multiply from the DONE cycle.
    drive(1'b1, 1'b1, 2'b00, 1'b1, 3'b000, 11'd0, 16'h0123); step();
    drive(1'b1, 1'b1, 2'b10, 1'b1, 3'b111, 11'd0, 16'h0045); step();
    check("mul_busy", busy_z, 32'h1);
    dones = 0;
    for (int i = 1; i <= DW; i++) begin
      if (i == 8) drive(1'b1, 1'b1, 2'b01, 1'b0, 3'b000, 11'd1, 16'h0000);
      else drive(1'b1, 1'b0, 2'b00, 1'b0, 3'b000, 11'd0, 16'h0000);
      step();
      dones += int'(done_z);
      if (i == 12) check("mul_hold", acc_z, 32'h0123);
    end
    check("mul_acc", acc_z, 32'h4E6F);
    check("mul_fl", flags_z, 32'h0);
    check("mul_done_cnt", dones, 32'd1);
    drive(1'b1, 1'b1, 2'b10, 1'b1, 3'b111, 11'd0, 16'h0002); step();
    check("b2b_busy", busy_s, 32'h1);
    check("b2b_done", done_s, 32'h0);
    drive(1'b1, 1'b0, 2'b00, 1'b0, 3'b000, 11'd0, 16'h0000);
    for (int i = 0; i < DW + 1; i++) step();
    check("b2b_acc", acc_s, 32'h9CDE);

    // Abort a multiply with reset at edge k+8.
    drive(1'b1, 1'b1, 2'b00, 1'b1, 3'b000, 11'd0, 16'h0123); step();
    drive(1'b1, 1'b1, 2'b10, 1'b1, 3'b111, 11'd0, 16'h0045); step();
    drive(1'b1, 1'b0, 2'b00, 1'b0, 3'b000, 11'd0, 16'h0000);
    for (int i = 0; i < 7; i++) step();
    drive(1'b0, 1'b1, 2'b10, 1'b1, 3'b111, 11'd0, 16'h0045); step();
    check("abort_acc", acc_z, 32'h0);
    check("abort_busy", busy_z, 32'h0);
    drive(1'b1, 1'b0, 2'b00, 1'b0, 3'b000, 11'd0, 16'h0000);
    dones = 0;
    for (int i = 0; i < DW + 4; i++) begin
      step();
      dones += int'(done_z);
    end
    check("abort_nodone", dones, 32'd0);
    drive(1'b1, 1'b1, 2'b10, 1'b1, 3'b000, 11'd0, 16'h0005); step();
    check("post_abort_add", acc_z, 32'h5);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) != 0),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            11'($urandom), 16'($urandom));
      step();
      check("rnd_opout", opo_s, {21'd0, operand});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bip_acc_datapath.md
# bip_acc_datapath

Parametrised accumulator datapath for the BIP processor family. It generalises the single-ALU accumulator path: configurable data and operand widths, optional sign extension of the immediate operand, an 8-operation ALU with a registered flag word, and a multi-cycle sequential multiplier with a BUSY/DONE handshake to the control unit. It sits between the instruction decoder (operand, selects, opcode) and data memory (DM_IN), and drives ACC back to memory and to the branch logic.

## Interface
- DATA_W, 16: accumulator, data memory and ALU width (≥ 4).
- OPERAND_W, 11: immediate operand width (< DATA_W).
- SIGN_EXT, 0: 0 zero-extends OPERAND_IN to DATA_W; 1 sign-extends it.
- CLK  in  1  single clock; all state updates on the rising edge.
- RESET_N  in  1  synchronous, active-low reset.
- OPERAND_IN  in  OPERAND_W  immediate from instruction.
- DM_IN  in  DATA_W  data memory read data.
- SEL_A  in  2  ACC source: 00 DM_IN, 01 extended operand, 10 ALU result, 11 reserved (no write).
- SEL_B  in  1  ALU B operand: 0 extended operand, 1 DM_IN.
- WR_ACC  in  1  accumulator write enable.
- OP  in  3  ALU opcode (see Operation).
- ACC  out  DATA_W  accumulator, registered.
- FLAGS  out  4  {Z, N, C, V}, registered.
- BUSY  out  1  multiplier in progress.
- DONE  out  1  one-cycle pulse when a multiply result lands in ACC.
- OPERAND_OUT  out  OPERAND_W  OPERAND_IN passed through combinationally.

## Operation
- Opcodes: 000 ADD, 001 SUB (ACC−B), 010 AND, 011 OR, 100 XOR, 101 SHL by 1, 110 SAR by 1 (arithmetic, B ignored), 111 MUL.
- Write with SEL_A=00/01: ACC ← source; Z, N updated from new value; C, V held.
- Write with SEL_A=10, OP≠MUL: single cycle. ACC ← ALU result, all flags updated.
  - ADD: C = carry out of bit DATA_W−1; V = signed overflow.
  - SUB: C = borrow (ACC < B unsigned); V = signed overflow.
  - AND/OR/XOR: C = 0, V = 0.
  - SHL: C = old ACC[DATA_W−1]; SAR: C = old ACC[0]; V = 0 for both.
- Write with SEL_A=10, OP=MUL: starts an unsigned shift-add multiply of ACC × B.
  - Operands captured at the start edge.
  - Result is the low DATA_W bits. C = 1 if any of the high DATA_W bits are nonzero; V = 0; Z, N from the result.
- SEL_A=11, or WR_ACC=0: ACC and FLAGS hold.
- FSM: IDLE → MUL on a MUL start. MUL iterates DATA_W cycles → IDLE with ACC/FLAGS written and DONE set.
- While BUSY: WR_ACC and all other inputs are ignored; ACC shows the pre-multiply value until completion.

## Timing
- Reset (RESET_N=0 at an edge): ACC=0, FLAGS=0000, BUSY=0, DONE=0, FSM=IDLE. Reset overrides every other input.
- Reset mid-multiply aborts the operation: no DONE, ACC=0.
- Single-cycle ops: result visible in ACC/FLAGS after the edge where WR_ACC=1.
- MUL started at edge k: BUSY=1 after edge k. ACC holds the product and BUSY=0 after edge k+DATA_W. DONE=1 only during the cycle following edge k+DATA_W.
- Back-to-back: a new WR_ACC is accepted in the DONE cycle itself. That includes another MUL, which reasserts BUSY after that edge with DONE dropping.
- OPERAND_OUT is combinational, with zero latency.

## Structure
- Package bip_dp_pkg: opcode constants, SEL_A encodings, flag bit indices (Z=3, N=2, C=1, V=0), FSM state enum.
- Sub-module bip_alu: combinational ALU for opcodes 000–110 plus flag generation, parametrised by DATA_W.
- The top level holds the operand mux, extension, ACC/FLAGS registers, and the MUL FSM with its shift/add registers.

## Test plan
All scenarios use DATA_W=16, OPERAND_W=11.
- Reset: hold RESET_N=0 for 2 cycles with WR_ACC=1 → ACC=0x0000, FLAGS=0000, BUSY=0, DONE=0.
- Immediate load of 0x7FF, SEL_A=01:
  - SIGN_EXT=0 → ACC=0x07FF, N=0.
  - SIGN_EXT=1 → ACC=0xFFFF, N=1, Z=0.
- ADD overflow: ACC=0x7FFF, DM_IN=0x0001, SEL_B=1, OP=ADD → ACC=0x8000, FLAGS Z0 N1 C0 V1.
- SUB borrow: ACC=0x0003, immediate 5, SEL_B=0, OP=SUB → ACC=0xFFFE, N=1, C=1, V=0. Then SHL → ACC=0xFFFC, C=1.
- MUL: ACC=0x0123, DM_IN=0x0045, OP=MUL.
  - BUSY high for 16 cycles; a WR_ACC load of 0x0001 mid-way is ignored.
  - Then ACC=0x4E6F, C=0, DONE pulses exactly one cycle.
- Abort: start MUL with ACC=0x0123, DM_IN=0x0045, and assert RESET_N=0 at cycle 8 → ACC=0, BUSY=0, no DONE pulse. A following ADD works normally.
